// File: rtl/barrel_shifter_pipe.sv
// Pipelined four-mode logarithmic barrel shifter (SRL/SRA/SLL/ROR).
// One register stage per mux level, global stall, valid/ready on both sides.
module barrel_shifter_pipe #(
    parameter int unsigned N = 8,
    localparam int unsigned SHW = $clog2(N),
    localparam int unsigned L = $clog2(N)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [N-1:0]   in_data,
    input  logic [SHW-1:0] in_amt,
    input  logic [1:0]     in_op,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [N-1:0]   out_data
);

    typedef enum logic [1:0] {
        OpSrl = 2'b00,
        OpSra = 2'b01,
        OpSll = 2'b10,
        OpRor = 2'b11
    } op_e;

    function automatic logic [N-1:0] bit_rev(input logic [N-1:0] d);
        logic [N-1:0] r;
        for (int b = 0; b < int'(N); b++) begin
            r[b] = d[int'(N)-1-b];
        end
        return r;
    endfunction

    // One mux level doing a right shift by s; SLL arrives pre-reversed and uses the SRL path.
    function automatic logic [N-1:0] level_shift(input logic [N-1:0] d, input int unsigned s,
                                                 input logic [1:0] op, input logic sign);
        logic [N-1:0] ones;
        logic [N-1:0] srl;
        logic [N-1:0] res;
        ones = '1;
        srl  = d >> s;
        unique case (op)
            OpSra:   res = srl | ({N{sign}} & ~(ones >> s));
            OpRor:   res = srl | (d << (N - s));
            default: res = srl;
        endcase
        return res;
    endfunction

    logic           valid_q [L];
    logic [N-1:0]   data_q  [L];
    logic [SHW-1:0] amt_q   [L];
    logic [1:0]     op_q    [L];
    logic           sign_q  [L];

    logic           valid_d [L];
    logic [N-1:0]   data_d  [L];
    logic [SHW-1:0] amt_d   [L];
    logic [1:0]     op_d    [L];
    logic           sign_d  [L];

    logic en;

    assign en        = ~out_valid | out_ready;
    assign in_ready  = en;
    assign out_valid = valid_q[L-1];
    assign out_data  = data_q[L-1];

    always_comb begin
        valid_d[0] = in_valid & en;
        data_d[0]  = (in_op == OpSll) ? bit_rev(in_data) : in_data;
        amt_d[0]   = in_amt;
        op_d[0]    = in_op;
        sign_d[0]  = in_data[N-1];
        for (int k = 1; k < int'(L); k++) begin
            valid_d[k] = valid_q[k-1];
            data_d[k]  = data_q[k-1];
            amt_d[k]   = amt_q[k-1];
            op_d[k]    = op_q[k-1];
            sign_d[k]  = sign_q[k-1];
        end
        for (int k = 0; k < int'(L); k++) begin
            if (amt_d[k][k]) begin
                data_d[k] = level_shift(data_d[k], 32'd1 << k, op_d[k], sign_d[k]);
            end
        end
        // Undo the SLL input reversal before the result is registered in the last stage.
        if (op_d[L-1] == OpSll) begin
            data_d[L-1] = bit_rev(data_d[L-1]);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < int'(L); k++) begin
                valid_q[k] <= 1'b0;
                data_q[k]  <= '0;
                amt_q[k]   <= '0;
                op_q[k]    <= '0;
                sign_q[k]  <= 1'b0;
            end
        end else if (en) begin
            for (int k = 0; k < int'(L); k++) begin
                valid_q[k] <= valid_d[k];
                data_q[k]  <= data_d[k];
                amt_q[k]   <= amt_d[k];
                op_q[k]    <= op_d[k];
                sign_q[k]  <= sign_d[k];
            end
        end
    end

endmodule

// File: tb/tb_barrel_shifter_pipe.sv
// Bench for barrel_shifter_pipe (N=8): directed vector table, stall/reset sequences,
// and a randomized run against an arithmetic reference model with an in-order scoreboard.
module tb_barrel_shifter_pipe;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic [2:0] in_amt;
    logic [1:0] in_op;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;

    int checks = 0;
    int errors = 0;

    barrel_shifter_pipe #(.N(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_amt    (in_amt),
        .in_op     (in_op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic [7:0] data;
        logic [2:0] amt;
        logic [1:0] op;
        logic [7:0] exp;
    } vec_t;

    function automatic logic [7:0] ref_shift(input logic [7:0] d, input int a,
                                             input logic [1:0] op);
        logic signed [7:0] sd;
        logic [15:0]       dd;
        logic [7:0]        r;
        sd = d;
        dd = {d, d};
        case (op)
            2'd0:    r = d >> a;
            2'd1:    r = sd >>> a;
            2'd2:    r = d << a;
            default: r = dd[7:0] >> a | d << (8 - a);
        endcase
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: decide transfers at negedge, when both sides are stable for the next edge.
    logic [7:0] sb[$];
    logic [7:0] mon_exp;
    always @(negedge clk) begin
        if (!rst_n) begin
            sb.delete();
        end else begin
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    chk("sb_unexpected_valid", {31'd0, out_valid}, 32'd0);
                end else begin
                    mon_exp = sb.pop_front();
                    chk("sb_data", {24'd0, out_data}, {24'd0, mon_exp});
                end
            end
            if (in_valid && in_ready) begin
                sb.push_back(ref_shift(in_data, int'(in_amt), in_op));
            end
        end
    end

    vec_t       vecs[12];
    vec_t       bp[5];
    logic [7:0] got[$];
    logic [31:0] r;
    int  idx;
    int  sent;
    int  guard;
    int  first;
    int  last;
    int  bad;
    bit  acc;
    bit  acc_out;

    initial begin
        vecs[0]  = '{"srl_b4", 8'hB4, 3'd3, 2'd0, 8'h16};
        vecs[1]  = '{"sra_b4", 8'hB4, 3'd3, 2'd1, 8'hF6};
        vecs[2]  = '{"sll_b4", 8'hB4, 3'd3, 2'd2, 8'hA0};
        vecs[3]  = '{"ror_b4", 8'hB4, 3'd3, 2'd3, 8'h96};
        vecs[4]  = '{"srl_a0", 8'hC3, 3'd0, 2'd0, 8'hC3};
        vecs[5]  = '{"sra_a0", 8'hC3, 3'd0, 2'd1, 8'hC3};
        vecs[6]  = '{"sll_a0", 8'hC3, 3'd0, 2'd2, 8'hC3};
        vecs[7]  = '{"ror_a0", 8'hC3, 3'd0, 2'd3, 8'hC3};
        vecs[8]  = '{"sra_a7", 8'h80, 3'd7, 2'd1, 8'hFF};
        vecs[9]  = '{"srl_a7", 8'h80, 3'd7, 2'd0, 8'h01};
        vecs[10] = '{"sll_a7", 8'h01, 3'd7, 2'd2, 8'h80};
        vecs[11] = '{"ror_a7", 8'h01, 3'd7, 2'd3, 8'h02};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_amt    = '0;
        in_op     = '0;
        out_ready = 1'b0;
        repeat (2) tick();
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_data", {24'd0, out_data}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        rst_n = 1'b1;
        tick();

        // Directed vectors, one at a time, checking the 3-cycle latency.
        out_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            in_valid = 1'b1;
            in_data  = vecs[i].data;
            in_amt   = vecs[i].amt;
            in_op    = vecs[i].op;
            tick();
            in_valid = 1'b0;
            tick();
            chk({vecs[i].name, "_early"}, {31'd0, out_valid}, 32'd0);
            tick();
            chk({vecs[i].name, "_valid"}, {31'd0, out_valid}, 32'd1);
            chk({vecs[i].name, "_data"}, {24'd0, out_data}, {24'd0, vecs[i].exp});
            tick();
        end

        // Throughput: 8 back-to-back items.
        got.delete();
        first = -1;
        last  = -1;
        for (int c = 0; c < 16; c++) begin
            in_valid = (c < 8);
            in_data  = 8'h1D * (c + 1);
            in_amt   = c[2:0];
            in_op    = c[1:0];
            tick();
            if (out_valid) begin
                got.push_back(out_data);
                if (first < 0) first = c;
                last = c;
            end
        end
        in_valid = 1'b0;
        chk("tput_count", got.size(), 32'd8);
        chk("tput_first_cycle", first, 32'd2);
        chk("tput_span", last - first, 32'd7);
        for (int k = 0; k < 8 && k < got.size(); k++) begin
            chk("tput_data", {24'd0, got[k]}, {24'd0, ref_shift(8'h1D * (k + 1), k % 8, 2'(k % 4))});
        end

        // Backpressure: only L items fit while the output is stalled.
        for (int k = 0; k < 5; k++) begin
            r     = $urandom;
            bp[k] = '{"bp", r[7:0], r[10:8], r[12:11], 8'h00};
            bp[k].exp = ref_shift(bp[k].data, int'(bp[k].amt), bp[k].op);
        end
        out_ready = 1'b0;
        idx = 0;
        #1;
        for (int c = 0; c < 8; c++) begin
            in_valid = (idx < 5);
            if (idx < 5) begin
                in_data = bp[idx].data;
                in_amt  = bp[idx].amt;
                in_op   = bp[idx].op;
            end
            acc = in_valid && in_ready;
            tick();
            if (acc) idx++;
        end
        chk("bp_accepted", idx, 32'd3);
        chk("bp_in_ready_low", {31'd0, in_ready}, 32'd0);
        chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
        chk("bp_head_data", {24'd0, out_data}, {24'd0, bp[0].exp});
        repeat (3) tick();
        chk("bp_hold_valid", {31'd0, out_valid}, 32'd1);
        chk("bp_hold_data", {24'd0, out_data}, {24'd0, bp[0].exp});
        out_ready = 1'b1;
        #1;
        got.delete();
        for (int c = 0; c < 20 && (idx < 5 || got.size() < 5); c++) begin
            in_valid = (idx < 5);
            if (idx < 5) begin
                in_data = bp[idx].data;
                in_amt  = bp[idx].amt;
                in_op   = bp[idx].op;
            end
            acc     = in_valid && in_ready;
            acc_out = out_valid && out_ready;
            if (acc_out) got.push_back(out_data);
            tick();
            if (acc) idx++;
        end
        in_valid = 1'b0;
        chk("bp_total_accepted", idx, 32'd5);
        chk("bp_drain_count", got.size(), 32'd5);
        for (int k = 0; k < 5 && k < got.size(); k++) begin
            chk("bp_drain_order", {24'd0, got[k]}, {24'd0, bp[k].exp});
        end

        // Reset with the pipe full.
        for (int c = 0; c < 3; c++) begin
            in_valid = 1'b1;
            in_data  = 8'hA5 ^ 8'(c);
            in_amt   = 3'(c + 1);
            in_op    = 2'(c);
            tick();
        end
        in_valid = 1'b0;
        rst_n    = 1'b0;
        tick();
        chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("midrst_out_data", {24'd0, out_data}, 32'd0);
        chk("midrst_in_ready", {31'd0, in_ready}, 32'd1);
        rst_n = 1'b1;
        bad = 0;
        repeat (6) begin
            tick();
            if (out_valid) bad++;
        end
        chk("midrst_no_stale", bad, 32'd0);

        // Randomized traffic with random backpressure; the scoreboard does the checking.
        sent  = 0;
        guard = 0;
        while (sent < 10000 && guard < 60000) begin
            r         = $urandom;
            out_ready = (r[1:0] != 2'b00);
            if (!in_valid && r[4:2] != 3'b000) begin
                in_valid = 1'b1;
                in_data  = r[15:8];
                in_amt   = r[18:16];
                in_op    = r[20:19];
            end
            #1;
            acc = in_valid && in_ready;
            tick();
            if (acc) begin
                sent++;
                in_valid = 1'b0;
            end
            guard++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 20 && sb.size() != 0; c++) tick();
        tick();
        chk("rand_sent", sent, 32'd10000);
        chk("rand_sb_empty", sb.size(), 32'd0);
        chk("rand_idle_valid", {31'd0, out_valid}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
